aes_core_param: RTL and testbench

- Iterative AES encryption core, successor to the fixed 128-bit, multi-block-handshake core.
- Key length is selected by parameter: AES-128 or AES-256.
- Computes one full round per clock with an on-the-fly key schedule, using a start/ready/done handshake.
- Sits between the SPI front end and the cyphertext return path; plaintext and key are captured once, at start.

---
 rtl/aes_pkg.sv | 77 +++++++
 rtl/aes_key_window.sv | 74 +++++++
 rtl/aes_core_param.sv | 119 +++++++++++
 tb/tb_aes_core_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and combinational primitives: S-box, xtime, MixColumns, SubWord.
package aes_pkg;

   // byte 0 of the block lives in [15] (the MSB)
   typedef logic [15:0][7:0] state_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   function automatic int nr_of(input int key_bits);
      return (key_bits == 256) ? 14 : 10;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] s;
      case (b)
         8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
         8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
         8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
         8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
         8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
         8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
         8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
         8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
         8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
         8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
         8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
         8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
         8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
         8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
         8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
         8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
         8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
         8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
         8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
         8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
         8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
         8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
         8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
         8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
         8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
         8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
         8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
         8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
         8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
         8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
         8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
         8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_key_window.sv
// On-the-fly AES key expansion: a sliding window of Nk words, advanced by four words per round.
module aes_key_window
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                load_i,
   input  logic                advance_i,
   input  logic [KEY_BITS-1:0] key_i,
   output logic [127:0]        round_key_o
);

   logic [KEY_BITS-1:0] win_q, win_d, next_win_s;
   logic [7:0]          rcon_q, rcon_d;
   logic                phase_q, phase_d;
   logic [31:0]         last_s, temp_s, n0_s, n1_s, n2_s, n3_s;

   // New words w[i..i+3]; the AES-256 odd phase uses SubWord only, without rotation or Rcon
   always_comb begin
      last_s = win_q[31:0];
      if ((KEY_BITS == 256) && phase_q) begin
         temp_s = sub_word(last_s);
      end else begin
         temp_s = sub_word({last_s[23:0], last_s[31:24]}) ^ {rcon_q, 24'h000000};
      end
      n0_s = win_q[KEY_BITS-1  -: 32] ^ temp_s;
      n1_s = win_q[KEY_BITS-33 -: 32] ^ n0_s;
      n2_s = win_q[KEY_BITS-65 -: 32] ^ n1_s;
      n3_s = win_q[KEY_BITS-97 -: 32] ^ n2_s;
   end

   if (KEY_BITS == 256) begin : g_k256
      assign next_win_s = {win_q[127:0], n0_s, n1_s, n2_s, n3_s};
   end else begin : g_k128
      assign next_win_s = {n0_s, n1_s, n2_s, n3_s};
   end

   // The round being computed this cycle uses the key the window is about to expose
   assign round_key_o = next_win_s[KEY_BITS-1 -: 128];

   // Window / Rcon / phase next-state
   always_comb begin
      win_d   = win_q;
      rcon_d  = rcon_q;
      phase_d = phase_q;
      if (load_i) begin
         win_d   = key_i;
         rcon_d  = 8'h01;
         phase_d = 1'b0;
      end else if (advance_i) begin
         win_d   = next_win_s;
         phase_d = (KEY_BITS == 256) ? ~phase_q : 1'b0;
         rcon_d  = phase_q ? rcon_q : xtime(rcon_q);
      end else begin
         win_d = win_q;
      end
   end

   // Key window state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         win_q   <= '0;
         rcon_q  <= 8'h00;
         phase_q <= 1'b0;
      end else begin
         win_q   <= win_d;
         rcon_q  <= rcon_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/aes_core_param.sv
// Iterative AES-128/256 encryption core: one full round per clock, start/ready/done handshake.
module aes_core_param
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                int_osc,
   input  logic                reset_n,
   input  logic                start,
   output logic                ready,
   input  logic [KEY_BITS-1:0] key,
   input  logic [127:0]        plaintext,
   output logic                done,
   output logic [127:0]        cyphertext
);

   localparam int NR = nr_of(KEY_BITS);

   if ((KEY_BITS != 128) && (KEY_BITS != 256)) begin : g_bad_key_bits
      $error("aes_core_param: KEY_BITS must be 128 or 256");
   end

   fsm_t         fsm_q, fsm_d;
   logic [3:0]   rnd_q, rnd_d;
   state_t       blk_q, blk_d;
   logic [127:0] ct_q, ct_d;
   logic         done_q, done_d, ready_q, ready_d;
   logic         load_s, adv_s;
   logic [127:0] rk_s, sr_s, mc_s, round_out_s;

   aes_key_window #(.KEY_BITS(KEY_BITS)) u_key (
      .clk_i       (int_osc),
      .rst_ni      (reset_n),
      .load_i      (load_s),
      .advance_i   (adv_s),
      .key_i       (key),
      .round_key_o (rk_s)
   );

   // Round datapath: SubBytes+ShiftRows fused per byte, then MixColumns, then AddRoundKey
   always_comb begin
      sr_s = '0;
      mc_s = '0;
      for (int i = 0; i < 16; i++) begin
         sr_s[127-8*i -: 8] = sbox(blk_q[15 - (4*(((i/4) + (i%4)) % 4) + (i%4))]);
      end
      for (int c = 0; c < 4; c++) begin
         mc_s[127-32*c -: 32] = mix_column(sr_s[127-32*c -: 32]);
      end
      round_out_s = ((rnd_q == 4'(NR)) ? sr_s : mc_s) ^ rk_s;
   end

   // Control FSM next-state and register updates
   always_comb begin
      fsm_d   = fsm_q;
      rnd_d   = rnd_q;
      blk_d   = blk_q;
      ct_d    = ct_q;
      done_d  = 1'b0;
      ready_d = 1'b0;
      load_s  = 1'b0;
      adv_s   = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (start) begin
               blk_d  = plaintext ^ key[KEY_BITS-1 -: 128];
               rnd_d  = 4'd1;
               load_s = 1'b1;
               fsm_d  = ROUND;
            end else begin
               ready_d = 1'b1;
            end
         end
         ROUND: begin
            adv_s = 1'b1;
            blk_d = round_out_s;
            if (rnd_q == 4'(NR)) begin
               ct_d   = round_out_s;
               done_d = 1'b1;
               fsm_d  = DONE;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         DONE: begin
            ready_d = 1'b1;
            fsm_d   = IDLE;
         end
         default: begin
            ready_d = 1'b1;
            fsm_d   = IDLE;
         end
      endcase
   end

   // Core state registers
   always_ff @(posedge int_osc or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q   <= IDLE;
         rnd_q   <= 4'd0;
         blk_q   <= '0;
         ct_q    <= 128'h0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         fsm_q   <= fsm_d;
         rnd_q   <= rnd_d;
         blk_q   <= blk_d;
         ct_q    <= ct_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign ready      = ready_q;
   assign done       = done_q;
   assign cyphertext = ct_q;

endmodule

// File: tb/tb_aes_core_param.sv
// Self-checking bench for aes_core_param: AES-128 and AES-256 instances against known-answer vectors.
module tb_aes_core_param;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start128 = 1'b0, start256 = 1'b0;
   logic [127:0] key128 = '0, pt128 = '0, pt256 = '0;
   logic [255:0] key256 = '0;
   logic         ready128, ready256, done128, done256;
   logic [127:0] ct128, ct256;

   int total = 0;
   int bad = 0;
   int n_done128 = 0;
   int n_done256 = 0;
   logic [127:0] sb128[$];
   logic [127:0] sb256[$];

   typedef struct {
      int           sel;
      logic [255:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;
   vec_t vt[5];

   always #5 clk = ~clk;

   aes_core_param #(.KEY_BITS(128)) dut128 (
      .int_osc(clk), .reset_n(reset_n), .start(start128), .ready(ready128),
      .key(key128), .plaintext(pt128), .done(done128), .cyphertext(ct128));

   aes_core_param #(.KEY_BITS(256)) dut256 (
      .int_osc(clk), .reset_n(reset_n), .start(start256), .ready(ready256),
      .key(key256), .plaintext(pt256), .done(done256), .cyphertext(ct256));

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // scoreboard pops on every done pulse
   always @(negedge clk) begin
      if (reset_n && done128) begin
         n_done128++;
         check("sb128_avail", 128'(sb128.size() > 0), 128'(1));
         if (sb128.size() > 0) check("ct128", ct128, sb128.pop_front());
      end
      if (reset_n && done256) begin
         n_done256++;
         check("sb256_avail", 128'(sb256.size() > 0), 128'(1));
         if (sb256.size() > 0) check("ct256", ct256, sb256.pop_front());
      end
   end

   task automatic run_vec(input int idx, input bit noise);
      int   lat, busy_hi, nd0, nr;
      logic rdy, dn;
      nr = (vt[idx].sel != 0) ? 14 : 10;
      @(posedge clk); #1;
      if (vt[idx].sel == 0) begin
         start128 = 1'b1; key128 = vt[idx].key[127:0]; pt128 = vt[idx].pt;
         sb128.push_back(vt[idx].ct); nd0 = n_done128;
      end else begin
         start256 = 1'b1; key256 = vt[idx].key; pt256 = vt[idx].pt;
         sb256.push_back(vt[idx].ct); nd0 = n_done256;
      end
      @(posedge clk); #1;
      start128 = 1'b0; start256 = 1'b0;
      lat = 0; busy_hi = 0;
      rdy = (vt[idx].sel != 0) ? ready256 : ready128;
      if (rdy) busy_hi++;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         if (noise) begin
            start128 = 1'($urandom_range(0, 1));
            key128   = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt128    = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         @(posedge clk); #1;
         rdy = (vt[idx].sel != 0) ? ready256 : ready128;
         dn  = (vt[idx].sel != 0) ? done256 : done128;
         if (rdy) busy_hi++;
         if (dn) lat = c;
      end
      start128 = 1'b0;
      check($sformatf("latency_v%0d", idx), 128'(lat), 128'(nr));
      check($sformatf("ready_busy_v%0d", idx), 128'(busy_hi), 128'(0));
      @(posedge clk); #1;
      dn  = (vt[idx].sel != 0) ? done256 : done128;
      rdy = (vt[idx].sel != 0) ? ready256 : ready128;
      check($sformatf("done_1cyc_v%0d", idx), 128'(dn), 128'(0));
      check($sformatf("ready_after_v%0d", idx), 128'(rdy), 128'(1));
      check($sformatf("done_count_v%0d", idx),
            128'(((vt[idx].sel != 0) ? n_done256 : n_done128) - nd0), 128'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           nd, p;
      int           de[3];
      logic [127:0] hexp[3];
      logic [127:0] hold;

      vt[0] = '{0, {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
      vt[1] = '{0, {128'h0, 128'h000102030405060708090a0b0c0d0e0f},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vt[2] = '{1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};
      vt[3] = '{0, {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c},
                128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
      vt[4] = '{1, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                128'h6bc1bee22e409f96e93d7e117393172a, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8};

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready128", 128'(ready128), 128'(1));
      check("rst_done128", 128'(done128), 128'(0));
      check("rst_ct128", ct128, 128'h0);
      check("rst_ready256", 128'(ready256), 128'(1));
      check("rst_ct256", ct256, 128'h0);
      @(negedge clk) reset_n = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(i, 1'b0);

      // inputs toggled randomly while busy must not disturb the block
      run_vec(0, 1'b1);
      nd = n_done128;
      repeat (6) @(posedge clk);
      #1;
      check("noise_no_extra_done", 128'(n_done128 - nd), 128'(0));

      // reset during round 5 abandons the block
      @(posedge clk); #1;
      start128 = 1'b1; key128 = vt[1].key[127:0]; pt128 = vt[1].pt;
      @(posedge clk); #1;
      start128 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_ready", 128'(ready128), 128'(1));
      check("midrst_done", 128'(done128), 128'(0));
      check("midrst_ct", ct128, 128'h0);
      nd = n_done128;
      @(negedge clk) reset_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("midrst_no_done", 128'(n_done128 - nd), 128'(0));
      check("midrst_ct_hold", ct128, 128'h0);
      run_vec(0, 1'b0);

      // start held high: three back-to-back blocks with different inputs
      hexp[0] = vt[0].ct; hexp[1] = vt[1].ct; hexp[2] = vt[3].ct;
      de[0] = -1; de[1] = -1; de[2] = -1;
      p = 0; hold = ct128;
      @(posedge clk); #1;
      start128 = 1'b1; key128 = vt[0].key[127:0]; pt128 = vt[0].pt;
      sb128.push_back(vt[0].ct);
      for (int e = 0; e < 50; e++) begin
         @(posedge clk); #1;
         if (e == 0) begin
            key128 = vt[1].key[127:0]; pt128 = vt[1].pt; sb128.push_back(vt[1].ct);
         end else if (e == 12) begin
            key128 = vt[3].key[127:0]; pt128 = vt[3].pt; sb128.push_back(vt[3].ct);
         end else if (e == 24) begin
            start128 = 1'b0;
         end
         if (done128 && p < 3) begin
            de[p] = e;
            hold  = hexp[p];
            p++;
         end
         if (p > 0) check($sformatf("hold_ct_e%0d", e), ct128, hold);
      end
      check("b2b_pulses", 128'(p), 128'(3));
      check("b2b_first", 128'(de[0]), 128'(10));
      check("b2b_gap1", 128'(de[1] - de[0]), 128'(12));
      check("b2b_gap2", 128'(de[2] - de[1]), 128'(12));

      repeat (4) @(posedge clk);
      #1;
      check("sb128_drained", 128'(sb128.size()), 128'(0));
      check("sb256_drained", 128'(sb256.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
